// File: rtl/timer_bank.sv
// timer_bank: a bank of independent programmable interval timers.
// Each channel counts enabled cycles up to a run-time loadable limit and
// emits a one-cycle terminal pulse. A channel either auto-reloads
// (periodic) or stops after one terminal event (one-shot) until restarted.
module timer_bank #(
  parameter int unsigned WIDTH         = 8,
  parameter int unsigned CHANNELS      = 4,
  parameter int unsigned DEFAULT_LIMIT = 10,
  localparam int unsigned CH_W         = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                         clk,
  input  logic                         rst_n_i,
  input  logic [CHANNELS-1:0]          en_i,
  input  logic [CHANNELS-1:0]          start_i,
  input  logic [CHANNELS-1:0]          clear_i,
  input  logic                         load_en_i,
  input  logic [CH_W-1:0]              load_ch_i,
  input  logic [WIDTH-1:0]             load_limit_i,
  input  logic                         load_mode_i,
  output logic [CHANNELS-1:0]          count_ended_o,
  output logic [CHANNELS-1:0]          busy_o,
  output logic                         any_ended_o,
  output logic [CHANNELS*WIDTH-1:0]    result_o
);

  localparam logic [1:0] ST_RUN  = 2'd0;
  localparam logic [1:0] ST_IDLE = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [CHANNELS-1:0] ended_d;
  logic [CHANNELS-1:0] ended_q;
  logic                any_q;
  logic [CHANNELS-1:0] run_q;

  for (genvar n = 0; n < CHANNELS; n++) begin : g_ch
    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;
    logic [WIDTH-1:0] lim_q;
    logic [WIDTH-1:0] lim_d;
    logic [WIDTH-1:0] res_q;
    logic             mode_q;
    logic             mode_d;
    logic [1:0]       st_q;
    logic [1:0]       st_d;
    logic             end_d;
    logic             load_hit;

    // Out-of-range channel numbers never match any channel, so they are dropped.
    assign load_hit = load_en_i && (load_ch_i == CH_W'(n));

    // Next-state for this channel: load beats clear, clear beats start, start beats counting.
    always_comb begin
      cnt_d  = cnt_q;
      lim_d  = lim_q;
      mode_d = mode_q;
      st_d   = st_q;
      end_d  = 1'b0;
      if (load_hit) begin
        lim_d  = load_limit_i;
        mode_d = load_mode_i;
        if (load_mode_i) begin
          st_d  = ST_IDLE;
          cnt_d = '0;
        end else begin
          st_d  = ST_RUN;
        end
      end else if (clear_i[n]) begin
        cnt_d = '0;
      end else if (start_i[n] && (st_q != ST_RUN)) begin
        st_d  = ST_RUN;
        cnt_d = '0;
      end else if ((st_q == ST_RUN) && en_i[n]) begin
        // >= so that a limit lowered below the current count still terminates.
        if (cnt_q >= lim_q) begin
          cnt_d = '0;
          end_d = 1'b1;
          if (mode_q) begin
            st_d = ST_DONE;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    end

    // Channel registers; result is a one-cycle-delayed copy of the count.
    always_ff @(posedge clk or negedge rst_n_i) begin
      if (!rst_n_i) begin
        cnt_q  <= '0;
        lim_q  <= WIDTH'(DEFAULT_LIMIT);
        mode_q <= 1'b0;
        st_q   <= ST_RUN;
        res_q  <= '0;
      end else begin
        cnt_q  <= cnt_d;
        lim_q  <= lim_d;
        mode_q <= mode_d;
        st_q   <= st_d;
        res_q  <= cnt_q;
      end
    end

    assign ended_d[n]                 = end_d;
    assign run_q[n]                   = (st_q == ST_RUN);
    assign result_o[n*WIDTH +: WIDTH] = res_q;
  end

  // Terminal pulses and their OR are registered together so they line up.
  always_ff @(posedge clk or negedge rst_n_i) begin
    if (!rst_n_i) begin
      ended_q <= '0;
      any_q   <= 1'b0;
    end else begin
      ended_q <= ended_d;
      any_q   <= |ended_d;
    end
  end

  // Channels sit in RUN during reset, so busy is masked to keep every output low while reset is held.
  assign busy_o        = run_q & {CHANNELS{rst_n_i}};
  assign count_ended_o = ended_q;
  assign any_ended_o   = any_q;

endmodule

// File: tb/tb_timer_bank.sv
// tb_timer_bank: directed self-checking bench for timer_bank.
// A default bank (WIDTH=8, CHANNELS=4) covers the main behaviour; a second
// bank (WIDTH=16, CHANNELS=6) covers out-of-range load channels and wide limits.
module tb_timer_bank;

  logic clk = 1'b0;
  logic rst_n = 1'b1;

  // Default-parameter bank
  logic [3:0]  en1, start1, clear1;
  logic        load_en1, load_mode1;
  logic [1:0]  load_ch1;
  logic [7:0]  load_limit1;
  logic [3:0]  ended1, busy1;
  logic        any1;
  logic [31:0] result1;

  // Wide bank
  logic [5:0]  en2, start2, clear2;
  logic        load_en2, load_mode2;
  logic [2:0]  load_ch2;
  logic [15:0] load_limit2;
  logic [5:0]  ended2, busy2;
  logic        any2;
  logic [95:0] result2;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  timer_bank u_dut (
    .clk(clk), .rst_n_i(rst_n), .en_i(en1), .start_i(start1), .clear_i(clear1),
    .load_en_i(load_en1), .load_ch_i(load_ch1), .load_limit_i(load_limit1),
    .load_mode_i(load_mode1), .count_ended_o(ended1), .busy_o(busy1),
    .any_ended_o(any1), .result_o(result1)
  );

  timer_bank #(.WIDTH(16), .CHANNELS(6), .DEFAULT_LIMIT(10)) u_dut2 (
    .clk(clk), .rst_n_i(rst_n), .en_i(en2), .start_i(start2), .clear_i(clear2),
    .load_en_i(load_en2), .load_ch_i(load_ch2), .load_limit_i(load_limit2),
    .load_mode_i(load_mode2), .count_ended_o(ended2), .busy_o(busy2),
    .any_ended_o(any2), .result_o(result2)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    en1 = '0; start1 = '0; clear1 = '0; load_en1 = 0; load_ch1 = '0; load_limit1 = '0; load_mode1 = 0;
    en2 = '0; start2 = '0; clear2 = '0; load_en2 = 0; load_ch2 = '0; load_limit2 = '0; load_mode2 = 0;
    #2 rst_n = 1'b0;
    #1;
    checks++; if ({result1, ended1, busy1, any1} !== 41'd0) $display("[TB] FAIL reset_async_dut1 got r=%h e=%b b=%b a=%b want 0", result1, ended1, busy1, any1); else passed++;
    checks++; if ({ended2, busy2, any2} !== 13'd0) $display("[TB] FAIL reset_async_dut2 got e=%b b=%b a=%b want 0", ended2, busy2, any2); else passed++;
    step(); step();
    rst_n = 1'b1;
    #1;
    checks++; if (busy1 !== 4'hF) $display("[TB] FAIL reset_busy1 got %b want 1111", busy1); else passed++;
    checks++; if (busy2 !== 6'h3F) $display("[TB] FAIL reset_busy2 got %b want 111111", busy2); else passed++;
    step();
    checks++; if (result1 !== 32'd0 || ended1 !== 4'd0) $display("[TB] FAIL reset_idle got r=%h e=%b want 0", result1, ended1); else passed++;
  endtask

  // Channel 0 with default limit 10: period 11, result runs 0..10.
  task automatic test_free_run();
    int pulses = 0;
    en1 = 4'b0001;
    for (int k = 1; k <= 33; k++) begin
      step();
      checks++; if (ended1 !== ((k % 11 == 0) ? 4'b0001 : 4'b0000)) $display("[TB] FAIL free_run_ended k=%0d got %b want %b", k, ended1, (k % 11 == 0) ? 4'b0001 : 4'b0000); else passed++;
      checks++; if (any1 !== (k % 11 == 0)) $display("[TB] FAIL free_run_any k=%0d got %b", k, any1); else passed++;
      checks++; if (result1[7:0] !== 8'((k - 1) % 11)) $display("[TB] FAIL free_run_result k=%0d got %0d want %0d", k, result1[7:0], (k - 1) % 11); else passed++;
      checks++; if (result1[31:8] !== 24'd0) $display("[TB] FAIL free_run_others k=%0d got %h want 0", k, result1[31:8]); else passed++;
      if (ended1[0]) pulses++;
    end
    en1 = '0;
    checks++; if (pulses !== 3) $display("[TB] FAIL free_run_pulses got %0d want 3", pulses); else passed++;
  endtask

  // Lower the limit to 5 while channel 0 sits at 7.
  task automatic test_limit_lower();
    en1 = 4'b0001;
    for (int k = 0; k < 7; k++) step();
    checks++; if (result1[7:0] !== 8'd6) $display("[TB] FAIL lower_pre got %0d want 6", result1[7:0]); else passed++;
    load_en1 = 1; load_ch1 = 2'd0; load_limit1 = 8'd5; load_mode1 = 0;
    step();
    load_en1 = 0;
    checks++; if (ended1 !== 4'd0 || busy1[0] !== 1'b1) $display("[TB] FAIL lower_load got e=%b b=%b want 0000 and busy", ended1, busy1); else passed++;
    for (int j = 1; j <= 13; j++) begin
      step();
      checks++; if (ended1[0] !== (j % 6 == 1)) $display("[TB] FAIL lower_ended j=%0d got %b", j, ended1[0]); else passed++;
      checks++; if (result1[7:0] !== ((j == 1) ? 8'd7 : 8'((j - 2) % 6))) $display("[TB] FAIL lower_result j=%0d got %0d want %0d", j, result1[7:0], (j == 1) ? 7 : (j - 2) % 6); else passed++;
    end
    en1 = '0;
  endtask

  // One-shot on channel 2 with limit 3, started twice.
  task automatic test_one_shot();
    en1 = 4'b0100;
    load_en1 = 1; load_ch1 = 2'd2; load_limit1 = 8'd3; load_mode1 = 1;
    step();
    load_en1 = 0;
    checks++; if (busy1[2] !== 1'b0) $display("[TB] FAIL oneshot_idle got busy=%b want 0", busy1[2]); else passed++;
    for (int k = 0; k < 3; k++) begin
      step();
      checks++; if (busy1[2] !== 1'b0 || result1[23:16] !== 8'd0 || ended1 !== 4'd0) $display("[TB] FAIL oneshot_wait got b=%b r=%0d e=%b", busy1[2], result1[23:16], ended1); else passed++;
    end
    for (int rep = 0; rep < 2; rep++) begin
      start1 = 4'b0100;
      step();
      start1 = '0;
      checks++; if (busy1[2] !== 1'b1) $display("[TB] FAIL oneshot_start rep=%0d got busy=%b want 1", rep, busy1[2]); else passed++;
      for (int e = 1; e <= 4; e++) begin
        step();
        checks++; if (ended1 !== ((e == 4) ? 4'b0100 : 4'b0000)) $display("[TB] FAIL oneshot_ended rep=%0d e=%0d got %b", rep, e, ended1); else passed++;
        checks++; if (result1[23:16] !== 8'(e - 1)) $display("[TB] FAIL oneshot_result rep=%0d e=%0d got %0d want %0d", rep, e, result1[23:16], e - 1); else passed++;
        checks++; if (busy1[2] !== (e < 4)) $display("[TB] FAIL oneshot_busy rep=%0d e=%0d got %b", rep, e, busy1[2]); else passed++;
      end
      for (int k = 0; k < 2; k++) begin
        step();
        checks++; if (busy1[2] !== 1'b0 || result1[23:16] !== 8'd0 || ended1 !== 4'd0) $display("[TB] FAIL oneshot_done rep=%0d got b=%b r=%0d e=%b", rep, busy1[2], result1[23:16], ended1); else passed++;
      end
    end
    en1 = '0;
  endtask

  // Limit 0 on channel 1: a pulse after every enabled edge only.
  task automatic test_limit_zero();
    logic [3:0] pat;
    int pulses = 0;
    pat = 4'b1101;
    load_en1 = 1; load_ch1 = 2'd1; load_limit1 = 8'd0; load_mode1 = 0;
    step();
    load_en1 = 0;
    for (int i = 0; i < 4; i++) begin
      en1 = {2'b00, pat[i], 1'b0};
      step();
      checks++; if (ended1 !== {2'b00, pat[i], 1'b0} || any1 !== pat[i]) $display("[TB] FAIL zero_pulse i=%0d got e=%b a=%b want bit=%b", i, ended1, any1, pat[i]); else passed++;
      if (ended1[1]) pulses++;
    end
    en1 = '0;
    step();
    checks++; if (ended1 !== 4'd0) $display("[TB] FAIL zero_quiet got %b want 0000", ended1); else passed++;
    checks++; if (pulses !== 3) $display("[TB] FAIL zero_count got %0d want 3", pulses); else passed++;
  endtask

  // Same-edge load/clear/start/enable on channel 3, then async reset mid-count.
  task automatic test_priority_and_reset();
    en1 = 4'b1000;
    for (int k = 0; k < 4; k++) step();
    load_en1 = 1; load_ch1 = 2'd3; load_limit1 = 8'd2; load_mode1 = 0;
    clear1 = 4'b1000; start1 = 4'b1000;
    step();
    load_en1 = 0; clear1 = '0; start1 = '0;
    checks++; if (busy1[3] !== 1'b1 || ended1 !== 4'd0) $display("[TB] FAIL prio_load got b=%b e=%b", busy1[3], ended1); else passed++;
    step();
    checks++; if (ended1 !== 4'b1000 || result1[31:24] !== 8'd4) $display("[TB] FAIL prio_effect got e=%b r=%0d want 1000 and 4", ended1, result1[31:24]); else passed++;
    step(); step();
    checks++; if (result1[31:24] !== 8'd1) $display("[TB] FAIL prio_wrap got %0d want 1", result1[31:24]); else passed++;
    rst_n = 1'b0;
    #2;
    checks++; if ({result1, ended1, busy1, any1} !== 41'd0) $display("[TB] FAIL midrun_reset got r=%h e=%b b=%b a=%b want 0", result1, ended1, busy1, any1); else passed++;
    step();
    rst_n = 1'b1;
    en1 = 4'b0001;
    for (int e = 1; e <= 11; e++) begin
      step();
      checks++; if (ended1 !== ((e == 11) ? 4'b0001 : 4'b0000)) $display("[TB] FAIL reset_limit e=%0d got %b", e, ended1); else passed++;
    end
    en1 = '0;
    checks++; if (busy1 !== 4'hF) $display("[TB] FAIL reset_state got busy=%b want 1111", busy1); else passed++;
  endtask

  // Wide bank: out-of-range load channels and a 16-bit limit of 1000.
  task automatic test_wide_bank();
    int pulses = 0;
    for (int c = 6; c <= 7; c++) begin
      load_en2 = 1; load_ch2 = 3'(c); load_limit2 = 16'd3; load_mode2 = 1;
      step();
      load_en2 = 0;
      checks++; if (busy2 !== 6'h3F) $display("[TB] FAIL range_ignore ch=%0d got %b want 111111", c, busy2); else passed++;
    end
    load_en2 = 1; load_ch2 = 3'd5; load_limit2 = 16'd1000; load_mode2 = 0;
    step();
    load_en2 = 0;
    en2 = 6'b100000;
    for (int e = 1; e <= 2002; e++) begin
      step();
      checks++; if (ended2 !== ((e % 1001 == 0) ? 6'b100000 : 6'b000000)) $display("[TB] FAIL wide_ended e=%0d got %b", e, ended2); else passed++;
      if (e == 1001) begin
        checks++; if (result2[95:80] !== 16'd1000) $display("[TB] FAIL wide_result got %0d want 1000", result2[95:80]); else passed++;
      end
      if (ended2[5]) pulses++;
    end
    en2 = '0;
    checks++; if (pulses !== 2) $display("[TB] FAIL wide_pulses got %0d want 2", pulses); else passed++;
  endtask

  // Guard against an unexpected stall of the sequence.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] timeout");
  end

  // Scenario sequence
  initial begin
    test_reset();
    test_free_run();
    test_limit_lower();
    test_one_shot();
    test_limit_zero();
    test_priority_and_reset();
    test_wide_bank();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
